wb_stage: RTL

- Writeback stage of the 5-stage RV32I pipeline and the sole driver of the register file write port (w_enable/w_addr/w_data).
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- Waits for load data from data memory, then aligns and sign- or zero-extends it.
- Issues exactly one registered write per retiring instruction that writes rd != x0.
- Exposes the pending-load destination to the hazard unit.

---
 rtl/rv5stage_pkg.sv | 20 ++
 rtl/load_extract.sv | 43 ++++
 rtl/wb_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv5stage_pkg.sv
// Shared types and encodings for the 5-stage RV32I pipeline.
package rv5stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    // Writeback stage control states
    typedef enum logic [0:0] {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half/word of a memory word and extends it to XLEN.
module load_extract
    import rv5stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    output logic [XLEN-1:0] data,
    output logic            illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte lane select by address offset
    always_comb begin
        byte_sel = rdata[7:0];
        case (byte_off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    // Half lane select; bit 0 of the offset is irrelevant for aligned halves
    assign half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

    // Width and sign extension; unknown encodings flagged as illegal
    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: sole driver of the register file write port. Retires
// non-loads in one cycle and holds loads until data memory responds.
module wb_stage
    import rv5stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_rd_we,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  mem_byte_off,
    input  logic [31:0] mem_result,

    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,

    output logic        w_enable,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,

    output logic        pend_valid,
    output logic [4:0]  pend_addr,
    output logic        err
);

    localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_t           state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic                ld_we_q,      ld_we_d;
    logic [REG_AW-1:0]   ld_addr_q,    ld_addr_d;
    logic [2:0]          ld_f3_q,      ld_f3_d;
    logic [1:0]          ld_off_q,     ld_off_d;
    logic                w_enable_q,   w_enable_d;
    logic [REG_AW-1:0]   w_addr_q,     w_addr_d;
    logic [XLEN-1:0]     w_data_q,     w_data_d;
    logic                pend_valid_q, pend_valid_d;
    logic [REG_AW-1:0]   pend_addr_q,  pend_addr_d;
    logic                err_q,        err_d;

    logic [XLEN-1:0]     ext_data;
    logic                ext_illegal;

    // Extract the loaded value from the latched load attributes
    load_extract u_load_extract (
        .rdata    (dmem_rdata),
        .funct3   (ld_f3_q),
        .byte_off (ld_off_q),
        .data     (ext_data),
        .illegal  (ext_illegal)
    );

    // State, counter, latched load attributes and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WB_IDLE;
            cnt_q        <= '0;
            ld_we_q      <= 1'b0;
            ld_addr_q    <= '0;
            ld_f3_q      <= '0;
            ld_off_q     <= '0;
            w_enable_q   <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ld_we_q      <= ld_we_d;
            ld_addr_q    <= ld_addr_d;
            ld_f3_q      <= ld_f3_d;
            ld_off_q     <= ld_off_d;
            w_enable_q   <= w_enable_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            err_q        <= err_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_we_d    = ld_we_q;
        ld_addr_d  = ld_addr_q;
        ld_f3_d    = ld_f3_q;
        ld_off_d   = ld_off_q;
        w_enable_d = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        err_d      = 1'b0;

        case (state_q)
            WB_IDLE: begin
                if (mem_valid) begin
                    if (mem_is_load) begin
                        state_d   = WB_WAIT_LOAD;
                        cnt_d     = '0;
                        ld_we_d   = mem_rd_we;
                        ld_addr_d = mem_rd_addr;
                        ld_f3_d   = mem_funct3;
                        ld_off_d  = mem_byte_off;
                    end else if (mem_rd_we && (mem_rd_addr != '0)) begin
                        w_enable_d = 1'b1;
                        w_addr_d   = mem_rd_addr;
                        w_data_d   = mem_result;
                    end
                end
            end
            WB_WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    // Data arriving on the last timeout cycle still retires
                    state_d = WB_IDLE;
                    cnt_d   = '0;
                    if (ext_illegal) begin
                        err_d = 1'b1;
                    end else if (ld_we_q && (ld_addr_q != '0)) begin
                        w_enable_d = 1'b1;
                        w_addr_d   = ld_addr_q;
                        w_data_d   = ext_data;
                    end
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    state_d = WB_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = WB_IDLE;
                cnt_d   = '0;
            end
        endcase

        pend_valid_d = (state_d == WB_WAIT_LOAD);
        pend_addr_d  = pend_valid_d ? ld_addr_d : '0;
    end

    assign mem_ready  = (state_q == WB_IDLE);
    assign w_enable   = w_enable_q;
    assign w_addr     = w_addr_q;
    assign w_data     = w_data_q;
    assign pend_valid = pend_valid_q;
    assign pend_addr  = pend_addr_q;
    assign err        = err_q;

endmodule
